// File: rtl/cache_line_refill.sv
// Cache-line refill engine: one aligned memory read, BEATS beats assembled, one-cycle RAM write.
// Optional REFILL_ERR_EN adds mem_rerr/err; an errored refill suppresses the RAM write.
module cache_line_refill #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 64,
  parameter int BEAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_index,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rvalid,
  input  logic [BEAT_W-1:0] mem_rdata,
`ifdef REFILL_ERR_EN
  input  logic              mem_rerr,
  output logic              err,
`endif
  output logic              ram_wen,
  output logic [3:0]        ram_windex,
  output logic [LINE_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done
);

  localparam int BEATS      = LINE_W / BEAT_W;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINE_BYTES = LINE_W / 8;

  // states: IDLE wait request | ADDR issue line read | RECV collect beats | WRITE RAM write + done
  typedef enum logic [1:0] {IDLE, ADDR, RECV, WRITE} state_t;

  state_t              state, next_state;
  logic [3:0]          index_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   buf_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q;
  logic                err_beat;

`ifdef REFILL_ERR_EN
  assign err_beat = mem_rerr;
`else
  assign err_beat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state    = state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    ram_wen       = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
`ifdef REFILL_ERR_EN
    err           = 1'b0;
`endif
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) next_state = ADDR;
      end
      ADDR: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) next_state = RECV;
      end
      RECV: begin
        if (mem_rvalid && (cnt_q == CNT_W'(BEATS - 1))) next_state = WRITE;
      end
      WRITE: begin
        ram_wen    = ~err_q;
        done       = 1'b1;
`ifdef REFILL_ERR_EN
        err        = err_q;
`endif
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Masking (rather than slicing) keeps every req_addr bit in the logic cone.
  always_ff @(posedge clk) begin
    if (rst) begin
      index_q <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            index_q <= req_index;
            addr_q  <= req_addr & ~ADDR_W'(LINE_BYTES - 1);
          end
        end
        ADDR: begin
          if (mem_req_ready) cnt_q <= '0;
        end
        RECV: begin
          if (mem_rvalid) begin
            for (int b = 0; b < BEATS; b++) begin
              if (cnt_q == CNT_W'(b)) buf_q[b*BEAT_W +: BEAT_W] <= mem_rdata;
            end
            cnt_q <= cnt_q + CNT_W'(1);
            if (err_beat) err_q <= 1'b1;
          end
        end
        WRITE: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign mem_req_addr = addr_q;
  assign ram_windex   = index_q;
  assign ram_wdata    = buf_q;

endmodule
